// File: rtl/inv_mix_columns_seq.sv
// InvMixColumns sequencer for the AES-256 decrypt round.
// Takes one 128-bit state over a valid/ready handshake and iterates it through
// COLS_PER_CYCLE column units, or passes it straight through on a bypass request.
// The result is held until the downstream round logic consumes it.
module inv_mix_columns_seq #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int unsigned STATE_W = 128;
    localparam int unsigned COL_W   = 32;
    localparam int unsigned NCOL    = 4;
    localparam int unsigned NGRP    = NCOL / COLS_PER_CYCLE;
    localparam int unsigned CNT_W   = (NGRP > 1) ? $clog2(NGRP) : 1;

    // Only 1, 2 or 4 column units divide the state evenly.
    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               fsm;
    logic [STATE_W-1:0]   work;
    logic [STATE_W-1:0]   work_run;
    logic [CNT_W-1:0]     cnt;
    logic                 last_grp;
    logic                 accept;

    // GF(2^8) multiply by 2, reduction polynomial 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One InvMixColumns column: rows of the circulant matrix 0e 0b 0d 09.
    function automatic logic [COL_W-1:0] inv_col(input logic [COL_W-1:0] c);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int unsigned i = 0; i < 4; i++) begin
            a[i]  = c[31 - 8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Handshake decode; DONE can hand off directly to the next state.
    assign in_ready  = (fsm == IDLE) || ((fsm == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign last_grp  = (cnt == CNT_W'(NGRP - 1));
    assign out_state = work;

    // Column units: rewrite the columns of group cnt, leave the rest untouched.
    always_comb begin
        int unsigned col_idx;
        int unsigned base;
        work_run = work;
        col_idx  = 0;
        base     = 0;
        for (int unsigned g = 0; g < COLS_PER_CYCLE; g++) begin
            col_idx = 32'(cnt) * COLS_PER_CYCLE + g;
            base    = (NCOL - 1 - col_idx) * COL_W;
            work_run[base +: COL_W] = inv_col(work[base +: COL_W]);
        end
    end

    // Sequencer: accept, iterate over column groups, hold result until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= IDLE;
            work      <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (fsm)
                IDLE, DONE: begin
                    if (accept) begin
                        work <= in_state;
                        cnt  <= '0;
                        busy <= 1'b1;
                        if (in_bypass) begin
                            fsm       <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            fsm       <= RUN;
                            out_valid <= 1'b0;
                        end
                    end else if ((fsm == DONE) && out_ready) begin
                        fsm       <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                RUN: begin
                    work <= work_run;
                    cnt  <= cnt + CNT_W'(1);
                    if (last_grp) begin
                        fsm       <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    fsm       <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed and randomized checks of inv_mix_columns_seq for 1, 2 and 4 column units.
module tb_inv_mix_columns_seq;

    localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [127:0] V1_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    localparam logic [127:0] V2_IN  = 128'hd5d5d7d6_01010101_9fdc589d_8e4da1bc;
    localparam logic [127:0] V2_OUT = 128'hd4d4d4d5_01010101_f20a225c_db135345;

    logic               clk = 1'b0;
    logic               rst;
    logic [127:0]       in_state;
    logic               in_bypass;
    logic [2:0]         in_valid;
    logic [2:0]         out_ready;
    logic [2:0]         in_ready;
    logic [2:0]         out_valid;
    logic [2:0]         busy;
    logic [2:0][127:0]  out_state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_state(in_state), .in_bypass(in_bypass), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_state(out_state[0]), .busy(busy[0]));

    inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_state(in_state), .in_bypass(in_bypass), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_state(out_state[1]), .busy(busy[1]));

    inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_state(in_state), .in_bypass(in_bypass), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_state(out_state[2]), .busy(busy[2]));

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Generic shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_imc(input logic [127:0] s);
        logic [7:0]   rot [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        logic [127:0] r = '0;
        logic [31:0]  col;
        logic [7:0]   acc;
        for (int c = 0; c < 4; c++) begin
            col = s[127 - 32*c -: 32];
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(col[31 - 8*k -: 8], rot[(k - row + 4) % 4]);
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    // Present one state for a single handshake; returns at negedge+1 after the accepting edge.
    task automatic accept(input int idx, input logic [127:0] st, input logic byp, input string tag);
        @(negedge clk);
        in_valid[idx] = 1'b1;
        in_state      = st;
        in_bypass     = byp;
        #1;
        check(tag, 128'(in_ready[idx]), 128'(1));
        @(negedge clk);
        in_valid[idx] = 1'b0;
        in_state      = 'x;
        in_bypass     = 1'b0;
        #1;
    endtask

    // Edges after the accepting edge until out_valid is seen (bounded).
    task automatic wait_valid(input int idx, output int lat);
        lat = 0;
        while (!out_valid[idx] && lat < 50) begin
            @(negedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume(input int idx, input string tag);
        @(negedge clk);
        out_ready[idx] = 1'b1;
        #1;
        @(negedge clk);
        out_ready[idx] = 1'b0;
        #1;
        check(tag, 128'(out_valid[idx]), 128'(0));
    endtask

    // Random traffic with a scoreboard queue of expected results.
    task automatic random_run(input int idx, input int n);
        logic [127:0] q[$];
        logic [127:0] st;
        logic         byp;
        int           sent = 0;
        int           got  = 0;
        int           cyc  = 0;
        while (got < n && cyc < 40 * n) begin
            @(negedge clk);
            st             = {$urandom, $urandom, $urandom, $urandom};
            byp            = ($urandom_range(0, 7) == 0);
            in_state       = st;
            in_bypass      = byp;
            in_valid[idx]  = (sent < n) && ($urandom_range(0, 3) != 0);
            out_ready[idx] = ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid[idx] && out_ready[idx]) begin
                if (q.size() == 0) begin
                    check("rand_spurious_valid", 128'(out_valid[idx]), 128'(0));
                end else begin
                    check("rand_state", out_state[idx], q.pop_front());
                end
                got++;
            end
            if (in_valid[idx] && in_ready[idx]) begin
                q.push_back(byp ? st : ref_imc(st));
                sent++;
            end
            cyc++;
        end
        check("rand_complete", 128'(got), 128'(n));
        @(negedge clk);
        in_valid[idx]  = 1'b0;
        out_ready[idx] = 1'b0;
        in_bypass      = 1'b0;
    endtask

    initial begin
        int  lat;
        logic seen;
        rst       = 1'b1;
        in_state  = '0;
        in_bypass = 1'b0;
        in_valid  = '0;
        out_ready = '0;

        // Reset values while rst is held
        #12;
        check("rst_out_valid", 128'(out_valid[0]), 128'(0));
        check("rst_busy", 128'(busy[0]), 128'(0));
        check("rst_out_state", out_state[0], 128'(0));
        check("rst_in_ready", 128'(in_ready[0]), 128'(1));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_in_ready", 128'(in_ready[0]), 128'(1));

        // Bypass: result visible right after the accepting edge, unchanged
        accept(0, V1_IN, 1'b1, "byp_accept");
        check("byp_out_valid", 128'(out_valid[0]), 128'(1));
        check("byp_out_state", out_state[0], V1_IN);
        check("byp_busy", 128'(busy[0]), 128'(1));

        // Asynchronous reset mid-cycle while a result is held
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 128'(out_valid[0]), 128'(0));
        check("arst_busy", 128'(busy[0]), 128'(0));
        check("arst_out_state", out_state[0], 128'(0));
        check("arst_in_ready", 128'(in_ready[0]), 128'(1));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_rel_in_ready", 128'(in_ready[0]), 128'(1));

        // Known vector, one column per cycle
        accept(0, V1_IN, 1'b0, "v1_accept");
        check("v1_busy", 128'(busy[0]), 128'(1));
        wait_valid(0, lat);
        check("v1_latency", 128'(lat), 128'(4));
        check("v1_out_state", out_state[0], V1_OUT);
        consume(0, "v1_consume");

        // Backpressure for 10 cycles, then simultaneous consume and accept
        accept(0, V1_IN, 1'b0, "bp_accept");
        wait_valid(0, lat);
        check("bp_latency", 128'(lat), 128'(4));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("bp_out_state_hold", out_state[0], V1_OUT);
            check("bp_in_ready_low", 128'(in_ready[0]), 128'(0));
        end
        @(negedge clk);
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        in_state     = V2_IN;
        #1;
        check("ho_in_ready", 128'(in_ready[0]), 128'(1));
        check("ho_out_valid", 128'(out_valid[0]), 128'(1));
        @(negedge clk);
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b0;
        #1;
        check("ho_run_out_valid", 128'(out_valid[0]), 128'(0));
        check("ho_run_busy", 128'(busy[0]), 128'(1));
        wait_valid(0, lat);
        check("ho_latency", 128'(lat), 128'(4));
        check("ho_out_state", out_state[0], V2_OUT);
        consume(0, "ho_consume");

        // Reset while RUN is on its third group: transaction must vanish
        accept(0, V1_IN, 1'b0, "mr_accept");
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mr_busy", 128'(busy[0]), 128'(0));
        check("mr_in_ready", 128'(in_ready[0]), 128'(1));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mr_rel_in_ready", 128'(in_ready[0]), 128'(1));
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (out_valid[0]) seen = 1'b1;
        end
        check("mr_no_out_valid", 128'(seen), 128'(0));
        accept(0, V2_IN, 1'b0, "mr2_accept");
        wait_valid(0, lat);
        check("mr2_latency", 128'(lat), 128'(4));
        check("mr2_out_state", out_state[0], V2_OUT);
        consume(0, "mr2_consume");

        // Two and four column units on the known vector
        accept(1, V1_IN, 1'b0, "c2_accept");
        wait_valid(1, lat);
        check("c2_latency", 128'(lat), 128'(2));
        check("c2_out_state", out_state[1], V1_OUT);
        consume(1, "c2_consume");
        accept(2, V1_IN, 1'b0, "c4_accept");
        wait_valid(2, lat);
        check("c4_latency", 128'(lat), 128'(1));
        check("c4_out_state", out_state[2], V1_OUT);
        consume(2, "c4_consume");

        // Random states against the reference model with random handshakes
        random_run(0, 1000);
        random_run(1, 300);
        random_run(2, 300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
